// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM encoding, response context and access-decode helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Everything the response stage needs about the accepted request.
    typedef struct packed {
        logic       ld;
        logic       err;
        logic [2:0] f3;
        logic [1:0] lane;
    } rsp_ctx_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return lane != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-byte write enables; synchronous write and
// registered read, no reset on the array or read register.
module dmem_bank #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][b] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit in front of dmem_bank: decodes RV32I
// access size, writes/reads at acceptance, responds after READ_LATENCY cycles.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] CNT_LAST = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic          live;
    logic          accept, req_ok, wr_en, rd_en;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, bank_q, shifted, ld_data;
    logic [AW-1:0] word_idx;
    rsp_ctx_t      ctx;
    logic          addr_unused;

    // Upper address bits are don't-care: the array wraps modulo 4*DEPTH.
    assign word_idx    = i_req_addr[AW+1:2];
    assign addr_unused = ^i_req_addr[31:AW+2];

    assign o_req_ready = live && (state == ST_IDLE);
    assign accept      = i_req_valid && o_req_ready;
    assign req_ok      = f3_legal(i_req_we, i_req_funct3) && !misaligned(i_req_funct3, i_req_addr[1:0]);
    assign wr_en       = accept && i_req_we && req_ok;
    assign rd_en       = accept && !i_req_we && req_ok;
    assign be          = byte_en(i_req_funct3, i_req_addr[1:0]);

    always_comb begin
        wdata_rep = i_req_wdata;
        case (i_req_funct3)
            F3_B:    wdata_rep = {4{i_req_wdata[7:0]}};
            F3_H:    wdata_rep = {2{i_req_wdata[15:0]}};
            default: wdata_rep = i_req_wdata;
        endcase
    end

    dmem_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
        .i_clk (i_clk),
        .we    (wr_en),
        .be    (be),
        .addr  (word_idx),
        .wdata (wdata_rep),
        .re    (rd_en),
        .rdata (bank_q)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_nxt   = '0;
                    state_nxt = (READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) state_nxt = ST_RESP;
                else                 cnt_nxt   = cnt + 2'd1;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // live holds ready low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            live  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctx <= '0;
        end else if (accept) begin
            ctx.ld   <= !i_req_we;
            ctx.err  <= !req_ok;
            ctx.f3   <= i_req_funct3;
            ctx.lane <= i_req_addr[1:0];
        end
    end

    always_comb begin
        shifted = bank_q >> {ctx.lane, 3'b000};
        ld_data = bank_q;
        case (ctx.f3)
            F3_B:    ld_data = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = bank_q;
        endcase
    end

    assign o_rsp_valid = (state == ST_RESP);
    assign o_rsp_err   = o_rsp_valid && ctx.err;
    assign o_rsp_rdata = (o_rsp_valid && ctx.ld && !ctx.err) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: latency-1 and latency-3 instances checked every cycle
// against a byte-addressed behavioural model, plus directed literal cases.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [2:0]  f3        [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        rdy       [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rsp_rdata [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu #(.DEPTH(256), .READ_LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(rdy[0]),
        .i_req_we(req_we[0]), .i_req_funct3(f3[0]),
        .i_req_addr(addr[0]), .i_req_wdata(wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
    );

    dmem_lsu #(.DEPTH(256), .READ_LATENCY(3)) u_l3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(rdy[1]),
        .i_req_we(req_we[1]), .i_req_funct3(f3[1]),
        .i_req_addr(addr[1]), .i_req_wdata(wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, i, act, exp, $time);
        end
    endfunction

    // Behavioural model: byte-addressed memory, size-aligned legality, one
    // pending response per instance due at a known cycle.
    logic [7:0]  bm [2][1024];
    bit          pend   [2];
    int          due    [2];
    logic [31:0] exp_rd [2];
    bit          exp_er [2];
    bit          prev_rst = 1'b0;

    function automatic void model_accept(input int i);
        int a, n;
        bit sgn, legal, ok;
        logic [31:0] v;
        a   = int'(addr[i][9:0]);
        n   = 0;
        sgn = 1'b0;
        v   = '0;
        case (f3[i])
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b010: n = 4;
            3'b100: n = 1;
            3'b101: n = 2;
            default: n = 0;
        endcase
        legal = (n != 0) && !(req_we[i] && f3[i][2]);
        ok    = legal && ((a % n) == 0);
        if (ok && req_we[i])
            for (int j = 0; j < n; j++) bm[i][a + j] = wdata[i][8*j +: 8];
        if (ok && !req_we[i]) begin
            for (int j = 0; j < n; j++) v[8*j +: 8] = bm[i][a + j];
            if (sgn && v[8*n - 1])
                for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        exp_rd[i] = (ok && !req_we[i]) ? v : 32'd0;
        exp_er[i] = !ok;
        pend[i]   = 1'b1;
        due[i]    = cyc + lat_of(i);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit ev, er;
            ev = pend[i] && (cyc == due[i]) && rst_n;
            if (!rst_n) pend[i] = 1'b0;
            er = rst_n && prev_rst && !pend[i];
            chk("ready",     i, 32'(rdy[i]),       32'(er));
            chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
            chk("rsp_err",   i, 32'(rsp_err[i]),   ev ? 32'(exp_er[i]) : 32'd0);
            chk("rsp_rdata", i, rsp_rdata[i],      ev ? exp_rd[i] : 32'd0);
            if (ev) pend[i] = 1'b0;
            if (er && req_valid[i]) model_accept(i);
        end
        prev_rst = rst_n;
    end

    task automatic start_req(input int i, input logic we, input logic [2:0] fn,
                             input logic [31:0] a, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_we[i] = we; f3[i] = fn; addr[i] = a; wdata[i] = wd;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rdy[i]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout inst%0d got=not_ready exp=ready", i);
        end
    endtask

    task automatic wait_rsp(input int i, output logic [31:0] rd, output logic er, output int lat);
        rd = '0; er = 1'b0; lat = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (rsp_valid[i]) begin rd = rsp_rdata[i]; er = rsp_err[i]; lat = t; break; end
        end
        if (lat == 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout inst%0d got=none exp=pulse", i);
        end
    endtask

    task automatic do_op(input int i, input logic we, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        start_req(i, we, fn, a, wd);
        wait_rsp(i, rd, er, lat);
    endtask

    task automatic preload(input int i);
        logic [31:0] rd_unused;
        logic        er_unused;
        int          lat_unused;
        for (int w = 0; w < 256; w++)
            do_op(i, 1'b1, 3'b010, 32'(w * 4), $urandom, rd_unused, er_unused, lat_unused);
    endtask

    task automatic rnd(input int i);
        logic [31:0] rd_unused, a;
        logic        er_unused;
        logic [2:0]  fn;
        int          lt, r;
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    fn = 3'b000;
                2, 3:    fn = 3'b001;
                4, 5:    fn = 3'b010;
                6:       fn = 3'b100;
                7:       fn = 3'b101;
                8:       fn = 3'b011;
                default: fn = 3'(($urandom_range(0, 1) != 0) ? 7 : 6);
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
            do_op(i, 1'($urandom_range(0, 1)), fn, a, $urandom, rd_unused, er_unused, lt);
            chk("rnd_latency", i, 32'(lt), 32'(lat_of(i)));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt, pulses;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; f3[i] = '0; addr[i] = '0; wdata[i] = '0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", i, 32'(rdy[i]), 32'd0);
            chk("rst_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_err",   i, 32'(rsp_err[i]), 32'd0);
            chk("rst_rdata", i, rsp_rdata[i], 32'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_release", 0, 32'(rdy[0]), 32'd1);

        fork
            preload(0);
            preload(1);
        join

        // Latency-1 directed sequence.
        do_op(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lt);
        chk("sw_err", 0, 32'(er), 32'd0);
        chk("sw_rdata", 0, rd, 32'd0);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lt);
        chk("lw_rdata", 0, rd, 32'hDEADBEEF);
        chk("lw_err", 0, 32'(er), 32'd0);
        chk("lw_latency", 0, 32'(lt), 32'd1);
        do_op(0, 1'b1, 3'b000, 32'h13, 32'h000000AA, rd, er, lt);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lt);
        chk("sb_lw", 0, rd, 32'hAAADBEEF);
        do_op(0, 1'b0, 3'b000, 32'h13, 32'd0, rd, er, lt);
        chk("lb", 0, rd, 32'hFFFFFFAA);
        do_op(0, 1'b0, 3'b100, 32'h13, 32'd0, rd, er, lt);
        chk("lbu", 0, rd, 32'h000000AA);
        do_op(0, 1'b1, 3'b001, 32'h12, 32'h00008001, rd, er, lt);
        do_op(0, 1'b0, 3'b001, 32'h12, 32'd0, rd, er, lt);
        chk("lh", 0, rd, 32'hFFFF8001);
        do_op(0, 1'b0, 3'b101, 32'h12, 32'd0, rd, er, lt);
        chk("lhu", 0, rd, 32'h00008001);
        do_op(0, 1'b0, 3'b001, 32'h11, 32'd0, rd, er, lt);
        chk("lh_mis_err", 0, 32'(er), 32'd1);
        chk("lh_mis_rdata", 0, rd, 32'd0);
        do_op(0, 1'b1, 3'b001, 32'h11, 32'h00007777, rd, er, lt);
        chk("sh_mis_err", 0, 32'(er), 32'd1);
        do_op(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lt);
        chk("mem_unchanged", 0, rd, 32'h8001BEEF);

        // Latency-3 directed sequence.
        do_op(1, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, er, lt);
        do_op(1, 1'b0, 3'b010, 32'h10, 32'd0, rd, er, lt);
        chk("l3_lw_rdata", 1, rd, 32'h11223344);
        chk("l3_latency", 1, 32'(lt), 32'd3);
        do_op(1, 1'b0, 3'b011, 32'h20, 32'd0, rd, er, lt);
        chk("f3_011_err", 1, 32'(er), 32'd1);
        chk("f3_011_rdata", 1, rd, 32'd0);
        do_op(1, 1'b1, 3'b010, 32'h20, 32'd0, rd, er, lt);
        do_op(1, 1'b1, 3'b100, 32'h20, 32'h000000FF, rd, er, lt);
        chk("sbu_err", 1, 32'(er), 32'd1);
        do_op(1, 1'b0, 3'b010, 32'h20, 32'd0, rd, er, lt);
        chk("sbu_nowrite", 1, rd, 32'd0);

        // Reset while a store's response is still pending.
        start_req(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 1, 32'(rdy[1]), 32'd0);
        chk("rst_async_valid", 1, 32'(rsp_valid[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
        end
        chk("rst_no_pulse", 1, 32'(pulses), 32'd0);
        chk("rst_ready_back", 1, 32'(rdy[1]), 32'd1);
        do_op(1, 1'b0, 3'b010, 32'h40, 32'd0, rd, er, lt);
        chk("store_survives_rst", 1, rd, 32'hCAFEF00D);

        for (int i = 0; i < 2; i++) begin
            do_op(i, 1'b1, 3'b010, 32'h400, 32'h12345678, rd, er, lt);
            do_op(i, 1'b0, 3'b010, 32'h0, 32'd0, rd, er, lt);
            chk("wrap", i, rd, 32'h12345678);
        end

        fork
            rnd(0);
            rnd(1);
        join

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The module SHALL be parametrised:
- DEPTH, default 256: number of 32-bit words; power of 2, 4..65536.
- READ_LATENCY, default 1: cycles from request acceptance to response; 1..4.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  module can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  access size/sign, RV32I encoding.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  load data, extended to 32 bits.
- o_rsp_err  out  1  misaligned or illegal access.

Function
REQ-004 A request SHALL be accepted on a rising edge where i_req_valid and o_req_ready are both 1; only one request SHALL be outstanding at a time.
REQ-005 The FSM SHALL have three states:
- IDLE: o_req_ready=1; moves to WAIT on acceptance.
- WAIT: counts READ_LATENCY-1 cycles; with READ_LATENCY=1 it is skipped and acceptance goes straight to RESP.
- RESP: o_rsp_valid=1 for exactly one cycle, then returns to IDLE.
REQ-006 o_req_ready SHALL be 1 only in IDLE. A request accepted at edge N SHALL produce o_rsp_valid during the cycle after edge N+READ_LATENCY-1. The next acceptance SHALL occur no earlier than edge N+READ_LATENCY+1.
REQ-007 Word index SHALL be i_req_addr[log2(DEPTH)+1:2]; byte lane SHALL be i_req_addr[1:0]. Higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-008 funct3 encodings:
- 000 byte, signed.
- 001 half, signed.
- 010 word.
- 100 byte, unsigned (load only).
- 101 half, unsigned (load only).
- Any other value, or 100/101 with i_req_we=1, SHALL be illegal.
REQ-009 Misaligned accesses SHALL be: half with addr[0]=1; word with addr[1:0]!=0.
REQ-010 A legal aligned store SHALL write memory at the acceptance edge using byte enables:
- byte: lane addr[1:0], data wdata[7:0].
- half: lanes addr[1]*2 and addr[1]*2+1, data wdata[15:0].
- word: all four lanes.
- Unselected bytes SHALL be unchanged.
REQ-011 A legal aligned load SHALL sample the word at the acceptance edge, then shift the selected byte/half to bit 0. Signed forms SHALL sign-extend; unsigned forms SHALL zero-extend.
REQ-012 A store response SHALL have o_rsp_rdata=0 and o_rsp_err=0.
REQ-013 An illegal or misaligned request SHALL:
- not write memory;
- still follow the REQ-006 timing;
- respond with o_rsp_err=1 and o_rsp_rdata=0.
REQ-014 A store followed by a load to the same word SHALL return the stored data. Read-after-write ordering is guaranteed by the single-outstanding rule.
REQ-015 Outside RESP, o_rsp_valid, o_rsp_err and o_rsp_rdata SHALL be 0.

Reset
REQ-016 While i_rst_n=0, the block SHALL be in this state, immediately and independent of the clock:
- FSM = IDLE; latency counter = 0.
- o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0.
- o_req_ready = 0.
REQ-017 o_req_ready SHALL rise in the first cycle after i_rst_n deasserts.
REQ-018 Memory contents SHALL NOT be reset.
REQ-019 Reset during WAIT or RESP SHALL discard the pending response. A store accepted before reset SHALL remain written.

Structure
REQ-020 Package dmem_pkg SHALL hold the funct3 constants, the FSM state encoding (IDLE/WAIT/RESP), and the alignment-check and byte-enable helper functions.
REQ-021 The storage array SHALL be a sub-module dmem_bank: DEPTH x 32, four byte-write enables, synchronous write, no reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios (READ_LATENCY=1 unless stated):
- Word round trip: sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid one cycle after acceptance.
- Byte store: sb wdata 0x000000AA @0x13, then lw @0x10 -> 0xAAADBEEF; lb @0x13 -> 0xFFFFFFAA; lbu @0x13 -> 0x000000AA.
- Halfword: sh 0x8001 @0x12; lh @0x12 -> 0xFFFF8001; lhu @0x12 -> 0x00008001; lh @0x11 -> err 1, rdata 0, memory unchanged.
- Latency and illegal op: with READ_LATENCY=3, lw accepted at edge N -> rsp_valid only in the cycle after edge N+2, ready low for edges N+1..N+3; funct3=011 -> err 1; sbu-style store (we=1, funct3=100) -> err 1, no write.
- Reset and wrap: DEPTH=256, assert i_rst_n=0 during WAIT -> rsp_valid never pulses, ready returns after release; sw 0x12345678 @0x400, then lw @0x0 -> 0x12345678.
